// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the writeback-port arbiter slice.
package rv_wb_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int NREG  = 32;

  // One queued secondary result. A cleared live bit means a younger
  // write to the same rd superseded it, so it must never reach the RF.
  typedef struct packed {
    logic             live;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

  // Who owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_PIPE = 2'd1,
    GRANT_HEAD = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Pipeline WB, secondary result and register-file write-port signals.
// The master is the surrounding core (or bench); the arbiter is the slave.
interface wb_port_arbiter_if;
  import rv_wb_pkg::*;

  logic             p_wb_enable;
  logic [REG_W-1:0] p_rd;
  logic [XLEN-1:0]  p_data;
  logic             p_stall;

  logic             s_valid;
  logic [REG_W-1:0] s_rd;
  logic [XLEN-1:0]  s_data;
  logic             s_ready;

  logic             rf_we;
  logic [REG_W-1:0] rf_rd;
  logic [XLEN-1:0]  rf_wdata;
  logic [NREG-1:0]  busy_mask;

  modport master (
    output p_wb_enable, p_rd, p_data, s_valid, s_rd, s_data,
    input  p_stall, s_ready, rf_we, rf_rd, rf_wdata, busy_mask
  );

  modport slave (
    input  p_wb_enable, p_rd, p_data, s_valid, s_rd, s_data,
    output p_stall, s_ready, rf_we, rf_rd, rf_wdata, busy_mask
  );

endinterface

// File: rtl/wb_kill_fifo.sv
// Circular queue of secondary results with per-rd kill. Entries that are
// killed stay in place (live=0) and are skipped when they reach the head.
// Slots outside the occupied range always hold live=0, so live_vec can be
// decoded directly without an occupancy mask.
module wb_kill_fifo
  import rv_wb_pkg::*;
#(
  parameter  int QDEPTH = 2,
  localparam int AW     = $clog2(QDEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  wb_entry_t                     push_entry,
  input  logic                          pop,
  input  logic                          kill,
  input  logic [REG_W-1:0]              kill_rd,
  output wb_entry_t                     head,
  output logic [AW:0]                   count,
  output logic                          empty,
  output logic [QDEPTH-1:0]             live_vec,
  output logic [QDEPTH-1:0][REG_W-1:0]  rd_vec
);

  wb_entry_t      q_r   [QDEPTH];
  wb_entry_t      q_nxt [QDEPTH];
  logic [AW:0]    wr_ptr, wr_nxt;
  logic [AW:0]    rd_ptr, rd_nxt;
  logic           full;
  logic           push_ok;
  logic           pop_ok;

  // Pointer compare: equal MSBs mean empty, differing MSBs mean full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = q_r[rd_ptr[AW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Per-entry view for the busy-mask decoder.
  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      live_vec[i] = q_r[i].live;
      rd_vec[i]   = q_r[i].rd;
    end
  end

  // Next queue state: kills first, then pop, then push so a same-cycle
  // arrival is never killed by the write it races with.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // any path that leaves one unassigned would infer a latch.
    q_nxt  = q_r;
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    for (int i = 0; i < QDEPTH; i++) begin
      if (kill && q_r[i].rd == kill_rd)
        q_nxt[i].live = 1'b0;
      if (push_ok && q_r[i].rd == push_entry.rd)
        q_nxt[i].live = 1'b0;
    end
    if (pop_ok) begin
      q_nxt[rd_ptr[AW-1:0]].live = 1'b0;
      rd_nxt = rd_ptr + (AW+1)'(1);
    end
    if (push_ok) begin
      q_nxt[wr_ptr[AW-1:0]] = push_entry;
      wr_nxt = wr_ptr + (AW+1)'(1);
    end
  end

  // Queue storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the whole entry array is reset, not only the pointers, so a
      // reset mid-drain cannot leave stale live bits visible in busy_mask.
      for (int i = 0; i < QDEPTH; i++) q_r[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples values from before this edge, independent of statement order.
      q_r    <= q_nxt;
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback normally wins,
// secondary results queue up with WAW kill, and a starvation counter
// stalls the pipeline so the queue is guaranteed to drain.
module wb_port_arbiter
  import rv_wb_pkg::*;
#(
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);

  localparam int AW = $clog2(QDEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_entry_t                     head;
  wb_entry_t                     push_entry;
  logic [AW:0]                   count;
  logic                          empty;
  logic [QDEPTH-1:0]             live_vec;
  logic [QDEPTH-1:0][REG_W-1:0]  rd_vec;

  logic             p_req;
  logic             head_live;
  logic             push;
  logic             pop;
  logic             kill;
  logic             p_stall;
  grant_e           grant;
  logic [SW-1:0]    starve_cnt;
  logic             rf_we_r;
  logic [REG_W-1:0] rf_rd_r;
  logic [XLEN-1:0]  rf_wdata_r;
  logic [NREG-1:0]  busy_mask;

  // Writes to x0 are architecturally void and never compete for the port.
  assign p_req      = bus.p_wb_enable && (bus.p_rd != '0);
  assign head_live  = !empty && head.live;
  assign p_stall    = (starve_cnt == SW'(STARVE_MAX));
  assign bus.s_ready = (count < (AW+1)'(QDEPTH));

  // Accepted x0 results are dropped here; they never occupy a slot.
  assign push       = bus.s_valid && bus.s_ready && (bus.s_rd != '0);
  assign push_entry = '{live: 1'b1, rd: bus.s_rd, data: bus.s_data};

  // A pipeline write that actually lands supersedes any queued result
  // for the same rd.
  assign kill = p_req && !p_stall;

  // Dead heads are discarded without using the port.
  assign pop = (grant == GRANT_HEAD) || (!empty && !head.live);

  wb_kill_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill       (kill),
    .kill_rd    (bus.p_rd),
    .head       (head),
    .count      (count),
    .empty      (empty),
    .live_vec   (live_vec),
    .rd_vec     (rd_vec)
  );

  // Port arbitration: a stalled pipeline yields to the live head,
  // otherwise pipeline first, then the queue.
  always_comb begin
    grant = GRANT_NONE;
    if (p_stall && head_live)
      grant = GRANT_HEAD;
    else if (p_req)
      grant = GRANT_PIPE;
    else if (head_live)
      grant = GRANT_HEAD;
  end

  // Starvation counter: counts consecutive pipeline wins over a live head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt <= '0;
    else if (grant == GRANT_HEAD || !head_live)
      starve_cnt <= '0;
    else if (grant == GRANT_PIPE && !p_stall)
      starve_cnt <= starve_cnt + SW'(1);
  end

  // Registered register-file write; address and data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_r    <= 1'b0;
      rf_rd_r    <= '0;
      rf_wdata_r <= '0;
    end else begin
      rf_we_r <= (grant != GRANT_NONE);
      case (grant)
        GRANT_PIPE: begin
          rf_rd_r    <= bus.p_rd;
          rf_wdata_r <= bus.p_data;
        end
        GRANT_HEAD: begin
          rf_rd_r    <= head.rd;
          rf_wdata_r <= head.data;
        end
        default: ;
      endcase
    end
  end

  // Busy mask decoded purely from queue flops, so it moves on the same
  // edge as the queue and never depends on this cycle's inputs.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < QDEPTH; i++)
      if (live_vec[i]) busy_mask[rd_vec[i]] = 1'b1;
  end

  assign bus.p_stall   = p_stall;
  assign bus.rf_we     = rf_we_r;
  assign bus.rf_rd     = rf_rd_r;
  assign bus.rf_wdata  = rf_wdata_r;
  assign bus.busy_mask = busy_mask;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (QDEPTH=2, STARVE_MAX=4).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_wb_port_arbiter;
  import rv_wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.QDEPTH(2), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic set_p(input logic en, input logic [4:0] rd, input logic [31:0] data);
    bus.p_wb_enable = en;
    bus.p_rd        = rd;
    bus.p_data      = data;
  endtask

  task automatic set_s(input logic v, input logic [4:0] rd, input logic [31:0] data);
    bus.s_valid = v;
    bus.s_rd    = rd;
    bus.s_data  = data;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    set_p(1'b0, 5'd0, 32'h0);
    set_s(1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_we",     32'(bus.rf_we),     32'h0);
    check("rst_rd",     32'(bus.rf_rd),     32'h0);
    check("rst_wdata",  bus.rf_wdata,       32'h0);
    check("rst_busy",   bus.busy_mask,      32'h0);
    check("rst_stall",  32'(bus.p_stall),   32'h0);
    check("rst_sready", 32'(bus.s_ready),   32'h1);
    rst = 1'b0;

    // 1: reset mid-drain with x5 queued behind a busy pipeline
    set_p(1'b1, 5'd1, 32'h1001);
    set_s(1'b1, 5'd5, 32'h55);
    cyc();
    set_s(1'b0, 5'd0, 32'h0);
    check("t1_busy5",   bus.busy_mask,      32'h0000_0020);
    cyc();
    check("t1_we_pre",  32'(bus.rf_we),     32'h1);
    #3 rst = 1'b1;
    #1;
    check("t1_we",      32'(bus.rf_we),     32'h0);
    check("t1_busy",    bus.busy_mask,      32'h0);
    check("t1_sready",  32'(bus.s_ready),   32'h1);
    check("t1_stall",   32'(bus.p_stall),   32'h0);
    check("t1_rd",      32'(bus.rf_rd),     32'h0);
    set_p(1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    check("t1_nodrain", 32'(bus.rf_we),     32'h0);
    check("t1_busy_post", bus.busy_mask,    32'h0);

    // 2: idle pipeline, single secondary result
    set_s(1'b1, 5'd7, 32'hDEAD_BEEF);
    cyc();
    set_s(1'b0, 5'd0, 32'h0);
    check("t2_busy7",   bus.busy_mask,      32'h0000_0080);
    check("t2_we0",     32'(bus.rf_we),     32'h0);
    cyc();
    check("t2_we",      32'(bus.rf_we),     32'h1);
    check("t2_rd",      32'(bus.rf_rd),     32'd7);
    check("t2_wdata",   bus.rf_wdata,       32'hDEAD_BEEF);
    check("t2_busy",    bus.busy_mask,      32'h0);
    cyc();
    check("t2_idle",    32'(bus.rf_we),     32'h0);

    // 3: starvation, x3 queued behind continuous pipeline writes
    set_p(1'b1, 5'd4, 32'h104);
    set_s(1'b1, 5'd3, 32'h11);
    cyc();
    set_s(1'b0, 5'd0, 32'h0);
    check("t3_rd4",     32'(bus.rf_rd),     32'd4);
    check("t3_busy3",   bus.busy_mask,      32'h0000_0008);
    check("t3_stall0",  32'(bus.p_stall),   32'h0);
    for (int k = 0; k < 4; k++) begin
      set_p(1'b1, 5'(5 + k), 32'h105 + 32'(k));
      cyc();
      check("t3_prd",   32'(bus.rf_rd),     32'(5 + k));
      check("t3_stall", 32'(bus.p_stall),   (k == 3) ? 32'h1 : 32'h0);
    end
    set_p(1'b1, 5'd9, 32'h109);
    cyc();
    check("t3_we",      32'(bus.rf_we),     32'h1);
    check("t3_rd3",     32'(bus.rf_rd),     32'd3);
    check("t3_wdata",   bus.rf_wdata,       32'h11);
    check("t3_unstall", 32'(bus.p_stall),   32'h0);
    check("t3_busy",    bus.busy_mask,      32'h0);
    cyc();
    check("t3_rd9",     32'(bus.rf_rd),     32'd9);
    check("t3_wdata9",  bus.rf_wdata,       32'h109);
    set_p(1'b0, 5'd0, 32'h0);
    cyc();
    check("t3_idle",    32'(bus.rf_we),     32'h0);

    // 4: WAW kill of queued x4 by a pipeline write
    set_p(1'b1, 5'd1, 32'h201);
    set_s(1'b1, 5'd4, 32'hAA);
    cyc();
    set_s(1'b0, 5'd0, 32'h0);
    check("t4_busy4",   bus.busy_mask,      32'h0000_0010);
    set_p(1'b1, 5'd4, 32'hBB);
    cyc();
    set_p(1'b0, 5'd0, 32'h0);
    check("t4_rd4",     32'(bus.rf_rd),     32'd4);
    check("t4_wdataBB", bus.rf_wdata,       32'hBB);
    check("t4_killed",  bus.busy_mask,      32'h0);
    cyc();
    check("t4_deadpop", 32'(bus.rf_we),     32'h0);
    check("t4_hold",    bus.rf_wdata,       32'hBB);
    cyc();
    check("t4_noAA_we", 32'(bus.rf_we),     32'h0);
    check("t4_noAA",    bus.rf_wdata,       32'hBB);
    check("t4_sready",  32'(bus.s_ready),   32'h1);

    // 5: full queue, order x2, x6, x8
    set_p(1'b1, 5'd1, 32'h301);
    set_s(1'b1, 5'd2, 32'h22);
    cyc();
    check("t5_busy2",   bus.busy_mask,      32'h0000_0004);
    check("t5_sready1", 32'(bus.s_ready),   32'h1);
    set_s(1'b1, 5'd6, 32'h66);
    cyc();
    check("t5_full",    32'(bus.s_ready),   32'h0);
    check("t5_busy26",  bus.busy_mask,      32'h0000_0044);
    set_s(1'b1, 5'd8, 32'h88);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t5_held",  32'(bus.s_ready),   32'h0);
      check("t5_busyh", bus.busy_mask,      32'h0000_0044);
      check("t5_prd",   32'(bus.rf_rd),     32'd1);
    end
    check("t5_stall",   32'(bus.p_stall),   32'h1);
    cyc();
    check("t5_rd2",     32'(bus.rf_rd),     32'd2);
    check("t5_wdata2",  bus.rf_wdata,       32'h22);
    check("t5_sready",  32'(bus.s_ready),   32'h1);
    check("t5_unstall", 32'(bus.p_stall),   32'h0);
    cyc();
    set_s(1'b0, 5'd0, 32'h0);
    set_p(1'b0, 5'd0, 32'h0);
    check("t5_rd1",     32'(bus.rf_rd),     32'd1);
    check("t5_busy68",  bus.busy_mask,      32'h0000_0140);
    cyc();
    check("t5_rd6",     32'(bus.rf_rd),     32'd6);
    check("t5_wdata6",  bus.rf_wdata,       32'h66);
    check("t5_busy8",   bus.busy_mask,      32'h0000_0100);
    cyc();
    check("t5_rd8",     32'(bus.rf_rd),     32'd8);
    check("t5_wdata8",  bus.rf_wdata,       32'h88);
    check("t5_busy0",   bus.busy_mask,      32'h0);
    cyc();
    check("t5_idle",    32'(bus.rf_we),     32'h0);

    // 6: x0 on both sources
    set_p(1'b1, 5'd0, 32'h999);
    set_s(1'b1, 5'd0, 32'h777);
    cyc();
    set_p(1'b0, 5'd0, 32'h0);
    set_s(1'b0, 5'd0, 32'h0);
    check("t6_we",      32'(bus.rf_we),     32'h0);
    check("t6_busy",    bus.busy_mask,      32'h0);
    check("t6_sready",  32'(bus.s_ready),   32'h1);
    cyc();
    check("t6_nostore", 32'(bus.rf_we),     32'h0);
    check("t6_rdhold",  32'(bus.rf_rd),     32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
